pipe_stage_reg: RTL



---
 rtl/pipe_stage_reg.sv | 91 +++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline stage register with valid/ready handshake, optional
// 2-entry skid buffer and synchronous flush. An empty stage presents a NOP control word.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              main_v;
  logic              skid_v;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              in_fire;
  logic              out_fire;

  // With a skid entry, in_ready depends only on a flop, cutting the out_ready->in_ready path.
  assign in_ready  = (SKID != 0) ? !skid_v : (!main_v | out_ready);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = main_v & out_ready;

  assign out_valid = main_v;
  assign out_data  = main_data;
  assign out_ctrl  = main_v ? main_ctrl : '0;
  assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_v    <= 1'b0;
      skid_v    <= 1'b0;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      main_v    <= 1'b0;
      skid_v    <= 1'b0;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (SKID == 0) begin
      if (in_fire) begin
        main_v    <= 1'b1;
        main_data <= in_data;
        main_ctrl <= in_ctrl;
      end else if (out_fire) begin
        main_v <= 1'b0;
      end
    end else begin
      if (!main_v) begin
        if (in_fire) begin
          main_v    <= 1'b1;
          main_data <= in_data;
          main_ctrl <= in_ctrl;
        end
      end else if (out_fire) begin
        // in_ready is low whenever skid_v is set, so a skid drain never coincides with a push.
        if (skid_v) begin
          main_data <= skid_data;
          main_ctrl <= skid_ctrl;
          skid_v    <= 1'b0;
        end else if (in_fire) begin
          main_data <= in_data;
          main_ctrl <= in_ctrl;
        end else begin
          main_v <= 1'b0;
        end
      end else if (in_fire) begin
        skid_v    <= 1'b1;
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
      end
    end
  end

endmodule
